// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the Lapido core: walks one instruction at a time
// through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over a shared memory port, with a watchdog trap.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int RETIRE_W    = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mem_ready,
  input  logic [31:0]         instr_in,
  output logic [31:0]         instruction,
  output logic                pcWrite,
  output logic                irWrite,
  output logic                iorD,
  output logic                memRead,
  output logic                memWrite,
  output logic [4:0]          ALUOp,
  output logic                ALUSrc,
  output logic                memToReg,
  output logic                regWrite,
  output logic                illegal,
  output logic                trap,
  output logic [2:0]          state,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

  state_t              r_state;
  state_t              w_state_next;
  logic [31:0]         r_ir;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [RETIRE_W-1:0] r_retired;

  logic w_cls_alu, w_cls_mem, w_cls_lit, w_valid, w_is_store, w_is_load;
  logic w_waiting, w_timeout, w_retire;

  assign w_cls_alu  = (r_ir[31:29] == 3'b001);
  assign w_cls_mem  = (r_ir[31:29] == 3'b100);
  assign w_cls_lit  = (r_ir[31:29] == 3'b010) && (r_ir[25:24] == 2'b10);
  assign w_valid    = w_cls_alu || w_cls_mem || w_cls_lit;
  assign w_is_store = w_cls_mem && r_ir[24];
  assign w_is_load  = w_cls_mem && !r_ir[24];

  // A ready in the final allowed wait cycle still completes the access.
  assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEMORY)) && !mem_ready;
  assign w_timeout = (MEM_TIMEOUT != 0) && w_waiting && (r_wait_cnt == WAIT_LAST);
  assign w_retire  = (r_state == S_WRITEBACK) ||
                     ((r_state == S_MEMORY) && mem_ready && w_is_store);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ir       <= '0;
      r_wait_cnt <= '0;
      r_retired  <= '0;
    end else begin
      if ((r_state == S_FETCH) && mem_ready) begin
        r_ir <= instr_in;
      end
      if (w_state_next != r_state) begin
        r_wait_cnt <= '0;
      end else if (w_waiting) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_retire) begin
        r_retired <= r_retired + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    pcWrite      = 1'b0;
    irWrite      = 1'b0;
    iorD         = 1'b0;
    memRead      = 1'b1;
    memWrite     = 1'b1;
    ALUOp        = 5'b00000;
    ALUSrc       = 1'b0;
    memToReg     = 1'b0;
    regWrite     = 1'b0;
    illegal      = 1'b0;
    case (r_state)
      S_FETCH: begin
        memRead = 1'b0;
        pcWrite = mem_ready;
        irWrite = mem_ready;
        if (mem_ready)      w_state_next = S_DECODE;
        else if (w_timeout) w_state_next = S_TRAP;
      end
      S_DECODE: begin
        illegal      = !w_valid;
        w_state_next = w_valid ? S_EXECUTE : S_FETCH;
      end
      S_EXECUTE: begin
        ALUOp        = w_cls_alu ? r_ir[28:24] : 5'b00000;
        ALUSrc       = !w_cls_alu;
        w_state_next = w_cls_mem ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        iorD     = 1'b1;
        ALUSrc   = 1'b1;
        memRead  = !w_is_load;
        memWrite = !w_is_store;
        if (mem_ready)      w_state_next = w_is_store ? S_FETCH : S_WRITEBACK;
        else if (w_timeout) w_state_next = S_TRAP;
      end
      S_WRITEBACK: begin
        regWrite     = 1'b1;
        memToReg     = w_is_load;
        w_state_next = S_FETCH;
      end
      S_TRAP: begin
        w_state_next = S_TRAP;
      end
      default: begin
        w_state_next = S_FETCH;
      end
    endcase
    // Reset forces every strobe inactive even though the state register updates only at the edge.
    if (reset) begin
      pcWrite  = 1'b0;
      irWrite  = 1'b0;
      iorD     = 1'b0;
      memRead  = 1'b1;
      memWrite = 1'b1;
      ALUOp    = 5'b00000;
      ALUSrc   = 1'b0;
      memToReg = 1'b0;
      regWrite = 1'b0;
      illegal  = 1'b0;
    end
  end

  assign trap        = (r_state == S_TRAP) && !reset;
  assign instruction = r_ir;
  assign state       = r_state;
  assign retired     = r_retired;

endmodule
